// File: rtl/uart_tx_frame_if.sv
// Host-side byte handshake for the UART transmitter.
`timescale 1ns/1ps
interface uart_tx_frame_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_busy;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  tx_busy
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output tx_busy
    );
endinterface

// File: rtl/uart_tx_frame.sv
// UART frame serializer: start bit, 8 data bits LSB-first, optional even parity,
// 1 or 2 stop bits, on a registered line that idles high.
`timescale 1ns/1ps
module uart_tx_frame #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_tx_frame_if.slave  host,
    output logic            tx
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic              stop_q, stop_d;
    logic [7:0]        shift_q, shift_d;
    logic              parity_q, parity_d;
    logic              tx_q, tx_d;
    logic              accept;
    logic              bit_end;

    // Handshake status depends on state alone, so reset frees the host at once.
    assign host.tx_ready = (state_q == IDLE);
    assign host.tx_busy  = (state_q != IDLE);
    assign tx            = tx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            stop_q   <= 1'b0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            stop_q   <= stop_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
        end
    end

    // tx_d is the line value for the next cycle, so it switches exactly on bit boundaries.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        stop_d   = stop_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        tx_d     = tx_q;
        accept   = host.tx_valid && (state_q == IDLE);
        bit_end  = (baud_q == BAUD_LAST);

        if (state_q != IDLE) begin
            baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (accept) begin
                    shift_d  = host.tx_data;
                    parity_d = ^host.tx_data;
                    baud_d   = '0;
                    bit_d    = '0;
                    stop_d   = 1'b0;
                    tx_d     = 1'b0;
                    state_d  = START;
                end
            end
            START: begin
                if (bit_end) begin
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        if (PARITY_EN != 0) begin
                            tx_d    = parity_q;
                            state_d = PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = STOP;
                        end
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    tx_d    = 1'b1;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop_q == STOP_LAST) begin
                        state_d = IDLE;
                    end else begin
                        stop_d = 1'b1;
                    end
                    tx_d = 1'b1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: one instance without parity/1 stop, one with parity/2 stops.
`timescale 1ns/1ps
module tb_uart_tx_frame;

    localparam int unsigned CPB = 4;

    typedef struct {
        logic [15:0] bits;
        int          nbits;
    } frame_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tx_a, tx_b;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int accepts_a = 0, accepts_b = 0;
    int pushed_a  = 0, pushed_b  = 0;

    frame_t exp_a[$];
    frame_t exp_b[$];
    int     acc_time_a[$];

    uart_tx_frame_if ifa ();
    uart_tx_frame_if ifb ();

    uart_tx_frame #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) dut_a (
        .clk  (clk),
        .rst_n(rst_n),
        .host (ifa.slave),
        .tx   (tx_a)
    );

    uart_tx_frame #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(2)) dut_b (
        .clk  (clk),
        .rst_n(rst_n),
        .host (ifb.slave),
        .tx   (tx_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic frame_t build(input logic [7:0] b, input bit par, input int stops);
        frame_t f;
        int k;
        f.bits = '0;
        k = 1;
        for (int i = 0; i < 8; i++) begin
            f.bits[k] = b[i];
            k++;
        end
        if (par) begin
            f.bits[k] = ^b;
            k++;
        end
        for (int i = 0; i < stops; i++) begin
            f.bits[k] = 1'b1;
            k++;
        end
        f.nbits = k;
        return f;
    endfunction

    // Pushes the expected frame, then offers the byte until it is taken.
    task automatic send(input int sel, input logic [7:0] b, input bit drop);
        int n;
        bit got;
        if (sel == 0) begin
            exp_a.push_back(build(b, 1'b0, 1));
            pushed_a++;
        end else begin
            exp_b.push_back(build(b, 1'b1, 2));
            pushed_b++;
        end
        @(negedge clk);
        if (sel == 0) begin
            ifa.tx_data = b; ifa.tx_valid = 1'b1;
        end else begin
            ifb.tx_data = b; ifb.tx_valid = 1'b1;
        end
        n = 0;
        got = 1'b0;
        while (!got && n < 200) begin
            @(posedge clk);
            n++;
            got = (sel == 0) ? ifa.tx_ready : ifb.tx_ready;
        end
        if (!got) check("accept_timeout", 32'd0, 32'd1);
        if (drop) begin
            @(negedge clk);
            if (sel == 0) ifa.tx_valid = 1'b0;
            else          ifb.tx_valid = 1'b0;
        end
    endtask

    // Detects each accept and checks every cycle of the frame against the popped expectation.
    task automatic monitor(input int sel);
        forever begin
            logic   v, r, line, rdy, bsy;
            frame_t f;
            int     flen;
            bit     aborted;
            string  nm;
            @(posedge clk);
            nm = (sel == 0) ? "a" : "b";
            v  = (sel == 0) ? ifa.tx_valid : ifb.tx_valid;
            r  = (sel == 0) ? ifa.tx_ready : ifb.tx_ready;
            if (rst_n && v && r) begin
                if (sel == 0) begin
                    accepts_a++;
                    acc_time_a.push_back(cyc);
                end else begin
                    accepts_b++;
                end
                if ((sel == 0 && exp_a.size() == 0) || (sel == 1 && exp_b.size() == 0)) begin
                    check({nm, "_unexpected_frame"}, 32'd1, 32'd0);
                    continue;
                end
                f = (sel == 0) ? exp_a.pop_front() : exp_b.pop_front();
                flen = f.nbits * CPB;
                aborted = 1'b0;
                for (int c = 0; c < flen; c++) begin
                    @(negedge clk);
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    line = (sel == 0) ? tx_a : tx_b;
                    rdy  = (sel == 0) ? ifa.tx_ready : ifb.tx_ready;
                    bsy  = (sel == 0) ? ifa.tx_busy : ifb.tx_busy;
                    check($sformatf("%s_bit%0d_cyc%0d", nm, c / CPB, c), line, f.bits[c / CPB]);
                    check($sformatf("%s_ready_low_cyc%0d", nm, c), rdy, 1'b0);
                    check($sformatf("%s_busy_high_cyc%0d", nm, c), bsy, 1'b1);
                end
                if (!aborted) begin
                    @(negedge clk);
                    if (rst_n) begin
                        line = (sel == 0) ? tx_a : tx_b;
                        rdy  = (sel == 0) ? ifa.tx_ready : ifb.tx_ready;
                        bsy  = (sel == 0) ? ifa.tx_busy : ifb.tx_busy;
                        check({nm, "_end_tx"}, line, 1'b1);
                        check({nm, "_end_ready"}, rdy, 1'b1);
                        check({nm, "_end_busy"}, bsy, 1'b0);
                    end
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int n;
        ifa.tx_valid = 1'b0; ifa.tx_data = 8'h00;
        ifb.tx_valid = 1'b0; ifb.tx_data = 8'h00;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_tx_a", tx_a, 1'b1);
        check("rst_ready_a", ifa.tx_ready, 1'b1);
        check("rst_busy_a", ifa.tx_busy, 1'b0);
        check("rst_tx_b", tx_b, 1'b1);
        check("rst_ready_b", ifb.tx_ready, 1'b1);
        check("rst_busy_b", ifb.tx_busy, 1'b0);
        repeat (10) begin
            @(negedge clk);
            check("idle_tx_a", tx_a, 1'b1);
            check("idle_tx_b", tx_b, 1'b1);
        end

        // single frame, no parity
        send(0, 8'hA5, 1'b1);
        repeat (45) @(negedge clk);

        // parity and two stop bits
        send(1, 8'hA5, 1'b1);
        repeat (53) @(negedge clk);
        send(1, 8'h07, 1'b1);
        repeat (53) @(negedge clk);

        // back-to-back with tx_valid held high
        base = acc_time_a.size();
        send(0, 8'h55, 1'b0);
        send(0, 8'hAA, 1'b1);
        repeat (45) @(negedge clk);
        if (acc_time_a.size() >= base + 2)
            check("b2b_accept_spacing", 32'(acc_time_a[base + 1] - acc_time_a[base]), 32'd41);
        else
            check("b2b_accept_count", 32'(acc_time_a.size()), 32'(base + 2));

        // offers while busy must be ignored
        base = accepts_a;
        send(0, 8'h3C, 1'b1);
        repeat (10) @(negedge clk);
        ifa.tx_valid = 1'b1; ifa.tx_data = 8'hFF;
        @(negedge clk);
        ifa.tx_data = 8'h00;
        @(negedge clk);
        ifa.tx_valid = 1'b0;
        n = 0;
        while (!ifa.tx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("busy_wait_ready", ifa.tx_ready, 1'b1);
        repeat (50) begin
            @(negedge clk);
            check("busy_no_second_frame_tx", tx_a, 1'b1);
        end
        check("busy_accept_count", 32'(accepts_a - base), 32'd1);

        // reset during data bit 3
        send(0, 8'hC3, 1'b1);
        repeat (17) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_tx", tx_a, 1'b1);
        check("midrst_ready", ifa.tx_ready, 1'b1);
        check("midrst_busy", ifa.tx_busy, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check("post_rst_idle_tx", tx_a, 1'b1);
            check("post_rst_idle_ready", ifa.tx_ready, 1'b1);
        end
        send(0, 8'h5A, 1'b1);
        repeat (45) @(negedge clk);

        check("accepts_a", 32'(accepts_a), 32'(pushed_a));
        check("accepts_b", 32'(accepts_b), 32'(pushed_b));
        check("pending_a", 32'(exp_a.size()), 32'd0);
        check("pending_b", 32'(exp_b.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Serial transmitter that turns parallel bytes into asynchronous UART frames (start, 8 data bits LSB-first, optional even parity, 1 or 2 stop bits) on a single registered output line. It accepts bytes from the host-side logic through a valid/ready handshake. It drives the board's TX pin, mirroring the receive path that captures the incoming serial line.

## Interface

- CLKS_PER_BIT, 434, clock cycles per bit period (50 MHz / 115200 baud); legal range ≥ 2
- PARITY_EN, 0, 1 = append even-parity bit after data; 0 = no parity bit
- STOP_BITS, 1, number of stop bits; legal values 1 or 2

- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- tx_data  input  8  byte to send; sampled only on the accept edge
- tx_valid  input  1  host offers tx_data
- tx_ready  output  1  block can accept a byte this cycle
- tx  output  1  serial line, idle high, driven from a flop
- tx_busy  output  1  frame in progress; equals ~tx_ready

## Operation

- Reset (rst_n low, asynchronous): state IDLE, tx=1, tx_ready=1, tx_busy=0, bit and baud counters cleared, shift register cleared. Takes effect immediately mid-frame: the frame is aborted, the line returns high, and nothing resumes after release.
- Accept: at a rising edge where tx_valid=1 and tx_ready=1, latch tx_data into the shift register and go to START. tx_valid while tx_ready=0 is ignored, not queued. tx_data changes during a frame have no effect.
- States:
  - IDLE: tx=1.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx=shift[0], shifted right each bit period. After bit 7, go to PARITY if PARITY_EN, else STOP.
  - PARITY: tx = XOR of the 8 latched bits (even parity), held one bit period, then STOP.
  - STOP: tx=1 for STOP_BITS bit periods, then IDLE.
- Baud counter: width $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary. It is reset to 0 on accept.
- Bit counter: 3 bits, indexes data bits 0..7. A separate stop counter handles STOP_BITS=2.
- Parity is computed from the latched byte, not from live tx_data.

## Timing

- Frame length F = (1 + 8 + PARITY_EN + STOP_BITS) × CLKS_PER_BIT cycles.
- Accept edge E0:
  - Immediately after E0: tx=0, tx_ready=0, tx_busy=1.
  - Data bit n appears on tx after edge E0 + (1+n)×CLKS_PER_BIT.
  - Parity bit, if enabled, appears after E0 + 9×CLKS_PER_BIT.
  - Stop bits follow the last data or parity bit.
- After edge E0+F: state IDLE, tx_ready=1, tx=1.
- Earliest next accept is edge E0+F+1. Back-to-back frames are therefore separated by exactly 1 idle-high cycle beyond the stop bits.
- tx changes only at bit boundaries and never glitches (registered).
- tx_ready and tx_busy are combinational from state only; they have no dependence on tx_valid.

## Test plan

- Reset values: hold rst_n=0 for 3 cycles, then release → tx=1, tx_ready=1, tx_busy=0. With tx_valid=0, tx stays 1 indefinitely.
- Single byte: CLKS_PER_BIT=4, PARITY_EN=0, STOP_BITS=1; send 0xA5 → tx sequence per 4-cycle period is 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop). tx_ready is low for exactly 40 cycles after the accept edge.
- Parity and two stop bits: CLKS_PER_BIT=4, PARITY_EN=1, STOP_BITS=2.
  - Send 0xA5 → parity bit 0.
  - Send 0x07 → parity bit 1.
  - Each frame is 48 cycles with 8 high cycles at the end.
- Back-to-back: hold tx_valid=1 with 0x55 then 0xAA → second accept occurs at edge E0+41 (CLKS_PER_BIT=4, no parity, 1 stop). Both bytes are serialized correctly with a 1-cycle gap.
- Busy-time stimulus: mid-frame, pulse tx_valid with 0xFF and change tx_data → current frame bits unchanged, and no second frame is sent.
- Reset mid-frame: assert rst_n=0 during data bit 3 → tx=1 and tx_ready=1 asynchronously, before the next clock edge. After release, the line stays idle until a new accept.
